// File: rtl/pwm_gate_pkg.sv
// Shared types and constants for the PWM gate-drive sequencer.
package pwm_gate_pkg;

  localparam int unsigned DT_WIDTH_DEFAULT = 8;
  localparam int unsigned DT_MIN           = 1;

  typedef enum logic [1:0] {
    PH_OFF  = 2'b00,
    PH_DEAD = 2'b01,
    PH_HIGH = 2'b10,
    PH_LOW  = 2'b11
  } phase_state_e;

endpackage

// File: rtl/pwm_phase_fsm.sv
// One half-bridge: dead-time sequencing FSM with complementary gate outputs.
module pwm_phase_fsm
  import pwm_gate_pkg::*;
#(
  parameter int unsigned DT_WIDTH = DT_WIDTH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                kill_i,
  input  logic                pwm_i,
  input  logic [DT_WIDTH-1:0] dt_i,
  output logic                udrive_o,
  output logic                ldrive_o,
  output logic                conduct_next_c
);

  phase_state_e          state_q, state_d;
  logic                  target_q, target_d;
  logic [DT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DT_WIDTH-1:0]   dt_load_c;

  // A zero dead time still holds both gates off for one cycle.
  assign dt_load_c = (dt_i < DT_WIDTH'(DT_MIN)) ? DT_WIDTH'(DT_MIN) : dt_i;

  // Next-state logic; kill overrides every other transition.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (kill_i) begin
      state_d = PH_OFF;
    end else begin
      case (state_q)
        PH_OFF: begin
          state_d  = PH_DEAD;
          target_d = pwm_i;
          cnt_d    = dt_load_c;
        end
        PH_DEAD: begin
          // Target follows the command throughout; the counter keeps running.
          target_d = pwm_i;
          if (cnt_q <= DT_WIDTH'(1)) begin
            state_d = target_q ? PH_HIGH : PH_LOW;
          end else begin
            cnt_d = cnt_q - DT_WIDTH'(1);
          end
        end
        PH_HIGH: begin
          if (!pwm_i) begin
            state_d  = PH_DEAD;
            target_d = 1'b0;
            cnt_d    = dt_load_c;
          end
        end
        PH_LOW: begin
          if (pwm_i) begin
            state_d  = PH_DEAD;
            target_d = 1'b1;
            cnt_d    = dt_load_c;
          end
        end
        default: state_d = PH_OFF;
      endcase
    end
  end

  assign conduct_next_c = (state_d == PH_HIGH) || (state_d == PH_LOW);

  // State register with gate outputs registered from the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PH_OFF;
      target_q <= 1'b0;
      cnt_q    <= '0;
      udrive_o <= 1'b0;
      ldrive_o <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      udrive_o <= (state_d == PH_HIGH);
      ldrive_o <= (state_d == PH_LOW);
    end
  end

endmodule

// File: rtl/pwm_gate_sequencer.sv
// Three-phase gate-drive sequencer: fault sync/latch, kill gating, per-phase FSMs.
module pwm_gate_sequencer
  import pwm_gate_pkg::*;
#(
  parameter int unsigned PHASES   = 3,
  parameter int unsigned DT_WIDTH = DT_WIDTH_DEFAULT
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic                enable,
  input  logic                fault_n,
  input  logic                clear_fault,
  input  logic [DT_WIDTH-1:0] dt_cycles,
  input  logic [PHASES-1:0]   pwm_in,
  output logic [PHASES-1:0]   udrive,
  output logic [PHASES-1:0]   ldrive,
  output logic                fault_latched,
  output logic                all_off
);

  logic              fault_meta_q, fault_s_q;
  logic              fault_latched_q, fault_latched_d;
  logic              all_off_q;
  logic              kill_c;
  logic [PHASES-1:0] conduct_c;

  // Two-flop synchroniser for the asynchronous fault input; resets to no-fault.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      fault_meta_q <= 1'b1;
      fault_s_q    <= 1'b1;
    end else begin
      fault_meta_q <= fault_n;
      fault_s_q    <= fault_meta_q;
    end
  end

  // Sticky fault: set wins over clear, clear only honoured once the fault is gone.
  always_comb begin
    fault_latched_d = fault_latched_q;
    if (!fault_s_q) begin
      fault_latched_d = 1'b1;
    end else if (clear_fault) begin
      fault_latched_d = 1'b0;
    end
  end

  assign kill_c = !enable || fault_latched_q || !fault_s_q;

  for (genvar g = 0; g < int'(PHASES); g++) begin : g_phase
    pwm_phase_fsm #(
      .DT_WIDTH (DT_WIDTH)
    ) u_phase (
      .clk            (clk_clk),
      .rst_n          (reset_reset_n),
      .kill_i         (kill_c),
      .pwm_i          (pwm_in[g]),
      .dt_i           (dt_cycles),
      .udrive_o       (udrive[g]),
      .ldrive_o       (ldrive[g]),
      .conduct_next_c (conduct_c[g])
    );
  end

  // Fault flag and all-off status registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      fault_latched_q <= 1'b0;
      all_off_q       <= 1'b1;
    end else begin
      fault_latched_q <= fault_latched_d;
      all_off_q       <= ~|conduct_c;
    end
  end

  assign fault_latched = fault_latched_q;
  assign all_off       = all_off_q;

endmodule

// File: tb/tb_pwm_gate_sequencer.sv
// Self-checking bench for pwm_gate_sequencer against a cycle-number based model.
module tb_pwm_gate_sequencer;

  localparam int PH  = 3;
  localparam int DTW = 8;
  localparam int M_OFF = 0, M_DEAD = 1, M_HIGH = 2, M_LOW = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           enable = 1'b0;
  logic           fault_n = 1'b1;
  logic           clear_fault = 1'b0;
  logic [DTW-1:0] dt = '0;
  logic [PH-1:0]  pwm = '0;
  logic [PH-1:0]  udrive, ldrive;
  logic           fault_latched, all_off;
  logic [2*PH+1:0] dut_vec;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: each phase mode, the absolute edge at which dead time ends,
  // the command seen at the previous edge, the fault pipeline and flag.
  int            m_mode [PH];
  int            m_end  [PH];
  logic [PH-1:0] m_prev;
  logic          m_fs1, m_fs2, m_flat;
  int            m_edge;

  pwm_gate_sequencer #(.PHASES(PH), .DT_WIDTH(DTW)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .enable        (enable),
    .fault_n       (fault_n),
    .clear_fault   (clear_fault),
    .dt_cycles     (dt),
    .pwm_in        (pwm),
    .udrive        (udrive),
    .ldrive        (ldrive),
    .fault_latched (fault_latched),
    .all_off       (all_off)
  );

  assign dut_vec = {udrive, ldrive, fault_latched, all_off};

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < PH; i++) begin
      m_mode[i] = M_OFF;
      m_end[i]  = 0;
    end
    m_prev = '0; m_fs1 = 1'b1; m_fs2 = 1'b1; m_flat = 1'b0; m_edge = 0;
  endtask

  // Apply one clock edge's worth of rules to the model using current inputs.
  task automatic model_step();
    bit kill;
    int d;
    m_edge++;
    kill = !enable || m_flat || !m_fs2;
    d = (dt == 0) ? 1 : int'(dt);
    for (int i = 0; i < PH; i++) begin
      if (kill) m_mode[i] = M_OFF;
      else if (m_mode[i] == M_OFF) begin
        m_mode[i] = M_DEAD; m_end[i] = m_edge + d;
      end else if (m_mode[i] == M_DEAD) begin
        if (m_edge >= m_end[i]) m_mode[i] = m_prev[i] ? M_HIGH : M_LOW;
      end else if ((m_mode[i] == M_HIGH && !pwm[i]) || (m_mode[i] == M_LOW && pwm[i])) begin
        m_mode[i] = M_DEAD; m_end[i] = m_edge + d;
      end
    end
    m_prev = pwm;
    if (!m_fs2) m_flat = 1'b1;
    else if (clear_fault) m_flat = 1'b0;
    m_fs2 = m_fs1;
    m_fs1 = fault_n;
  endtask

  function automatic logic [2*PH+1:0] model_vec();
    logic [PH-1:0] u, l;
    for (int i = 0; i < PH; i++) begin
      u[i] = (m_mode[i] == M_HIGH);
      l[i] = (m_mode[i] == M_LOW);
    end
    return {u, l, m_flat, ~|(u | l)};
  endfunction

  // Advance one clock: DUT and model see the same inputs; returns at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(negedge clk);
    n_tests++;
    if (dut_vec !== 8'b000_000_0_1) begin
      n_fail++;
      $display("FAIL reset_state: got %b want %b", dut_vec, 8'b000_000_0_1);
    end
  endtask

  task automatic test_startup();
    rst_n = 1'b1; enable = 1'b1; fault_n = 1'b1; dt = 8'd4; pwm = 3'b101;
    for (int c = 1; c <= 8; c++) begin
      tick();
      n_tests++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL startup_model c=%0d: got %b want %b", c, dut_vec, model_vec());
      end
      n_tests++;
      if ({udrive, ldrive} !== ((c <= 4) ? 6'b000_000 : 6'b101_010)) begin
        n_fail++;
        $display("FAIL startup_gates c=%0d: got %b", c, {udrive, ldrive});
      end
    end
  endtask

  task automatic test_deadtime();
    pwm = 3'b100;
    for (int c = 1; c <= 6; c++) begin
      tick();
      n_tests++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL deadtime_model c=%0d: got %b want %b", c, dut_vec, model_vec());
      end
      n_tests++;
      if ({udrive[0], ldrive[0]} !== ((c <= 4) ? 2'b00 : 2'b01)) begin
        n_fail++;
        $display("FAIL deadtime_phaseA c=%0d: got u=%b l=%b", c, udrive[0], ldrive[0]);
      end
    end
    pwm = 3'b101;
    repeat (6) tick();
  endtask

  task automatic test_glitch();
    dt = 8'd10;
    pwm = 3'b100;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) pwm = 3'b101;
      if (c == 2) pwm = 3'b100;
      n_tests++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL glitch_model c=%0d: got %b want %b", c, dut_vec, model_vec());
      end
      n_tests++;
      if ({udrive[0], ldrive[0]} !== ((c >= 11) ? 2'b01 : 2'b00)) begin
        n_fail++;
        $display("FAIL glitch_phaseA c=%0d: got u=%b l=%b", c, udrive[0], ldrive[0]);
      end
    end
    dt = 8'd4; pwm = 3'b101;
    repeat (12) tick();
  endtask

  task automatic test_fault();
    fault_n = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      fault_n = 1'b1;
      n_tests++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL fault_model c=%0d: got %b want %b", c, dut_vec, model_vec());
      end
      if (c >= 3) begin
        n_tests++;
        if ({udrive, ldrive, fault_latched} !== 7'b000_000_1) begin
          n_fail++;
          $display("FAIL fault_kill c=%0d: got %b want 0000001", c, {udrive, ldrive, fault_latched});
        end
      end
    end
    clear_fault = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      clear_fault = 1'b0;
      n_tests++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL fault_clear_model c=%0d: got %b want %b", c, dut_vec, model_vec());
      end
      n_tests++;
      if ({udrive, ldrive, fault_latched} !== ((c <= 5) ? 7'b000_000_0 : 7'b101_010_0)) begin
        n_fail++;
        $display("FAIL fault_recover c=%0d: got %b", c, {udrive, ldrive, fault_latched});
      end
    end
  endtask

  task automatic test_dt_bounds();
    dt = 8'd0; pwm = 3'b100;
    for (int c = 1; c <= 2; c++) begin
      tick();
      n_tests++;
      if ({udrive[0], ldrive[0]} !== ((c == 2) ? 2'b01 : 2'b00) || dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL dt_zero c=%0d: got %b want %b", c, dut_vec, model_vec());
      end
    end
    dt = 8'd255; pwm = 3'b101;
    for (int c = 1; c <= 257; c++) begin
      tick();
      n_tests++;
      if (udrive[0] !== (c >= 256) || dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL dt_max c=%0d: got %b want %b", c, dut_vec, model_vec());
      end
    end
    dt = 8'd10; pwm = 3'b100;
    repeat (3) tick();
    enable = 1'b0;
    tick();
    n_tests++;
    if (dut_vec !== 8'b000_000_0_1 || dut_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL enable_drop: got %b want %b", dut_vec, 8'b000_000_0_1);
    end
    enable = 1'b1;
    repeat (3) tick();
    n_tests++;
    if (dut_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL enable_reentry: got %b want %b", dut_vec, model_vec());
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < PH; i++)
        if ($urandom_range(0, 7) == 0) pwm[i] = ~pwm[i];
      if ($urandom_range(0, 15) == 0) dt = DTW'($urandom_range(0, 5));
      if (enable && $urandom_range(0, 199) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 9) == 0) enable = 1'b1;
      fault_n     = ($urandom_range(0, 299) != 0);
      clear_fault = ($urandom_range(0, 39) == 0);
      tick();
      n_tests++;
      if (dut_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL random_model c=%0d: got %b want %b", c, dut_vec, model_vec());
      end
      n_tests++;
      if ((udrive & ldrive) !== '0) begin
        n_fail++;
        $display("FAIL random_overlap c=%0d: u=%b l=%b want no overlap", c, udrive, ldrive);
      end
    end
    fault_n = 1'b1; clear_fault = 1'b0;
  endtask

  task automatic test_async_reset();
    enable = 1'b1; fault_n = 1'b1; dt = 8'd2; pwm = 3'b111;
    repeat (3) tick();
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    repeat (6) tick();
    n_tests++;
    if (dut_vec !== 8'b111_000_0_0 || dut_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL pre_reset_high: got %b want %b", dut_vec, 8'b111_000_0_0);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (dut_vec !== 8'b000_000_0_1) begin
      n_fail++;
      $display("FAIL async_reset: got %b want %b", dut_vec, 8'b000_000_0_1);
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_deadtime();
    test_glitch();
    test_fault();
    test_dt_bounds();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_gate_sequencer.md
Name: pwm_gate_sequencer

Overview:
Gate-drive controller between the PWM generator and one motor's three half-bridges (AH/AL, BH/BL, CH/CL).
- Converts a per-phase commanded high-side state into complementary high/low gate signals.
- Inserts programmable dead time on every transition; the high and low switches of a phase are never on together.
- Provides enable gating and a latched, synchronised fault shutdown.
- Instantiated once per motor, between the PWM core's drive outputs and the M*_PWM_* pins.

Parameters:
PHASES, 3, number of half-bridges handled
DT_WIDTH, 8, width of the dead-time cycle count

Ports:
clk_clk  input  1  system clock (50 MHz)
reset_reset_n  input  1  reset, asynchronous assert, active-low
enable  input  1  1 = phases may conduct; 0 = all gates off
fault_n  input  1  external driver fault, active-low, asynchronous to clk_clk
clear_fault  input  1  single-cycle pulse, clears latched fault
dt_cycles  input  DT_WIDTH  dead time in clk_clk cycles
pwm_in  input  PHASES  commanded state per phase (1 = high side on, 0 = low side on)
udrive  output  PHASES  high-side gate drive, registered
ldrive  output  PHASES  low-side gate drive, registered
fault_latched  output  1  sticky fault flag, registered
all_off  output  1  1 when every phase is in OFF or DEAD (no gate on)

Behaviour:
- Reset (async, reset_reset_n=0):
  - all phase FSMs go to OFF.
  - udrive=0, ldrive=0, fault_latched=0, all_off=1.
  - fault synchroniser flops are set to 1 (no fault).
- fault_n passes through a 2-flop synchroniser giving fault_s; fault_n low is seen 2 cycles later.
- Fault latch:
  - fault_s=0 sets fault_latched on the next edge.
  - clear_fault clears it only when fault_s=1.
  - A simultaneous set and clear resolves to set.
- kill = !enable | fault_latched | !fault_s.
- Per-phase FSM states: OFF, DEAD, HIGH, LOW. Each phase has a registered target bit and a DT_WIDTH down-counter.
  - OFF: if !kill → DEAD, target=pwm_in[i], counter loaded with max(dt_cycles,1).
  - DEAD: target re-sampled from pwm_in[i] every cycle; the counter is not restarted. At counter==1 → HIGH if target=1, else LOW. Otherwise decrement.
  - HIGH: if pwm_in[i]=0 → DEAD, counter loaded.
  - LOW: if pwm_in[i]=1 → DEAD, counter loaded.
  - Any state: kill=1 → OFF. kill takes priority over all other transitions.
- Outputs decode the registered state: udrive[i]=(state==HIGH), ldrive[i]=(state==LOW).
  - Both are 0 in OFF and DEAD.
  - Invariant: udrive[i]&ldrive[i]==0 on every cycle.
- Latency:
  - pwm_in toggles while sampled in HIGH/LOW at edge E → both gates low after edge E+1 → opposite gate on after edge E+1+max(dt_cycles,1).
  - kill sampled at edge E → gates low after edge E+1.
- dt_cycles is sampled only on DEAD entry; changes mid-DEAD take effect at the next transition. dt_cycles=0 behaves as 1.
- A pwm_in pulse shorter than the dead time gives no conduction of the opposite side beyond the DEAD state; the final target wins.
- Leaving kill: every phase re-enters through DEAD, never directly into HIGH or LOW.
- all_off is registered: the NOR over phases of (HIGH|LOW) next-state.

Decomposition:
- Shared package pwm_gate_pkg holds:
  - the phase-state enum (OFF, DEAD, HIGH, LOW, 2-bit encoding);
  - DT_MIN=1;
  - the default DT_WIDTH.
- Natural sub-module: pwm_phase_fsm, which contains one phase's FSM, counter and output decode.
  - The top instantiates it PHASES times.
  - The top owns the synchroniser, the fault latch, kill and all_off.

Test Plan:
- Reset release, enable=1, fault_n=1, dt_cycles=4, pwm_in=3'b101 → gates all 0 for 4 cycles after OFF exit, then udrive=101, ldrive=010.
- Phase A steady HIGH, pwm_in[0] 1→0 at edge E, dt=4 → udrive[0]=0 from E+1, ldrive[0]=1 from E+5; never both 1.
- DEAD with dt=10; pwm_in[0] glitches 0→1→0 within 3 cycles → phase ends in LOW at the original expiry; udrive[0] stays 0 throughout.
- fault_n low for 1 cycle while conducting → all gates 0 within 3 edges; fault_latched=1 persists; clear_fault with fault_n=1 → flag clears, phases pass through DEAD (dt cycles) before conducting.
- dt_cycles=0 → dead time exactly 1 cycle; dt_cycles=255 → 255 cycles with no counter wrap; enable dropped mid-DEAD → OFF next edge.
- Assert reset_reset_n low asynchronously while in HIGH → udrive/ldrive 0 immediately without a clock edge; all_off=1.
